// File: rtl/alu_share_arb.sv
// Two-port arbiter sharing a single-cycle ALU. The response register is one
// deep, with a burst limit so port 0 cannot starve port 1.
module alu_share_arb #(
    parameter int DW       = 32,
    parameter int OPW      = 4,
    parameter int P0_BURST = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_op,
    input  logic [DW-1:0]  req0_a,
    input  logic [DW-1:0]  req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_op,
    input  logic [DW-1:0]  req1_a,
    input  logic [DW-1:0]  req1_b,
    output logic [OPW-1:0] alu_op,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    input  logic [DW-1:0]  alu_c,
    input  logic           alu_zero,
    input  logic           alu_sgn,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [DW-1:0]  rsp_c,
    output logic           rsp_zero,
    output logic           rsp_sgn
);

    typedef enum logic {EMPTY, FULL} state_t;

    localparam int            BW        = $clog2(P0_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(P0_BURST);

    state_t          state_q, state_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic            rsp_id_q, rsp_id_d;
    logic [DW-1:0]   rsp_c_q, rsp_c_d;
    logic            rsp_zero_q, rsp_zero_d;
    logic            rsp_sgn_q, rsp_sgn_d;

    logic can_issue;
    logic grant0;
    logic grant1;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        burst_d    = burst_q;
        rsp_id_d   = rsp_id_q;
        rsp_c_d    = rsp_c_q;
        rsp_zero_d = rsp_zero_q;
        rsp_sgn_d  = rsp_sgn_q;
        alu_op     = '0;
        alu_a      = '0;
        alu_b      = '0;

        // rst_n gating keeps both readies low while reset is asserted.
        can_issue = rst_n && ((state_q == EMPTY) || rsp_ready);
        grant0    = can_issue && req0_valid && (!req1_valid || (burst_q != BURST_MAX));
        grant1    = can_issue && req1_valid && !grant0;

        if (grant0) begin
            alu_op = req0_op;
            alu_a  = req0_a;
            alu_b  = req0_b;
        end else if (grant1) begin
            alu_op = req1_op;
            alu_a  = req1_a;
            alu_b  = req1_b;
        end

        if (!req1_valid || grant1) begin
            burst_d = '0;
        end else if (grant0 && (burst_q != BURST_MAX)) begin
            burst_d = burst_q + 1'b1;
        end

        if (grant0 || grant1) begin
            state_d    = FULL;
            rsp_id_d   = grant1;
            rsp_c_d    = alu_c;
            rsp_zero_d = alu_zero;
            rsp_sgn_d  = alu_sgn;
        end else if ((state_q == FULL) && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            burst_q    <= '0;
            rsp_id_q   <= 1'b0;
            rsp_c_q    <= '0;
            rsp_zero_q <= 1'b0;
            rsp_sgn_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            rsp_id_q   <= rsp_id_d;
            rsp_c_q    <= rsp_c_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_sgn_q  <= rsp_sgn_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp_valid  = (state_q == FULL);
    assign rsp_id     = rsp_id_q;
    assign rsp_c      = rsp_c_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_sgn    = rsp_sgn_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb. A small behavioural ALU closes the loop,
// and each check compares against a hand-computed value.
module tb_alu_share_arb;

    localparam int DW  = 32;
    localparam int OPW = 4;
    localparam logic [OPW-1:0] OP_ADD = 4'd0;
    localparam logic [OPW-1:0] OP_SUB = 4'd1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req0_valid, req0_ready;
    logic [OPW-1:0] req0_op;
    logic [DW-1:0]  req0_a, req0_b;
    logic           req1_valid, req1_ready;
    logic [OPW-1:0] req1_op;
    logic [DW-1:0]  req1_a, req1_b;
    logic [OPW-1:0] alu_op;
    logic [DW-1:0]  alu_a, alu_b, alu_c;
    logic           alu_zero, alu_sgn;
    logic           rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_sgn;
    logic [DW-1:0]  rsp_c;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    // Opcode 0 adds, opcode 1 subtracts, and any other opcode ANDs.
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_c = alu_a + alu_b;
            OP_SUB:  alu_c = alu_a - alu_b;
            default: alu_c = alu_a & alu_b;
        endcase
        alu_zero = (alu_c == '0);
        alu_sgn  = alu_c[DW-1];
    end

    alu_share_arb #(.DW(DW), .OPW(OPW), .P0_BURST(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_c      (alu_c),
        .alu_zero   (alu_zero),
        .alu_sgn    (alu_sgn),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_c      (rsp_c),
        .rsp_zero   (rsp_zero),
        .rsp_sgn    (rsp_sgn)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns past the next rising edge; inputs change and checks happen there.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [OPW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    endtask

    task automatic set1(input logic v, input logic [OPW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    endtask

    logic exp_g1 [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        set0(1'b1, OP_ADD, 32'd5, 32'd7);
        set1(1'b0, OP_ADD, 32'd0, 32'd0);

        // Reset state; ready must stay low even though port 0 is requesting.
        #3;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_c", rsp_c, 32'd0);
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        #4 rst_n = 1'b1;
        cycle();
        set0(1'b0, OP_ADD, 32'd0, 32'd0);
        cycle();

        // Single port-0 ADD
        set0(1'b1, OP_ADD, 32'd5, 32'd7);
        #1;
        check("t1_req0_ready", 32'(req0_ready), 32'd1);
        check("t1_req1_ready", 32'(req1_ready), 32'd0);
        check("t1_alu_a", alu_a, 32'd5);
        check("t1_alu_b", alu_b, 32'd7);
        cycle();
        set0(1'b0, OP_ADD, 32'd0, 32'd0);
        #1;
        check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t1_rsp_c", rsp_c, 32'd12);
        check("t1_rsp_zero", 32'(rsp_zero), 32'd0);
        check("t1_rsp_sgn", 32'(rsp_sgn), 32'd0);
        check("t1_rsp_id", 32'(rsp_id), 32'd0);

        // Idle drain: the ALU mux is zero with no grant, and the data fields hold.
        check("t6_alu_op", 32'(alu_op), 32'd0);
        check("t6_alu_a", alu_a, 32'd0);
        check("t6_alu_b", alu_b, 32'd0);
        check("t6_ready0", 32'(req0_ready), 32'd0);
        check("t6_ready1", 32'(req1_ready), 32'd0);
        cycle();
        check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t6_rsp_c_hold", rsp_c, 32'd12);

        // Contention: expected grant sequence 0,0,1,0,0,1
        set0(1'b1, OP_ADD, 32'd1, 32'd1);
        set1(1'b1, OP_ADD, 32'd10, 32'd10);
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("t2_ready0_%0d", i), 32'(req0_ready), 32'(!exp_g1[i]));
            check($sformatf("t2_ready1_%0d", i), 32'(req1_ready), 32'(exp_g1[i]));
            cycle();
            check($sformatf("t2_rsp_id_%0d", i), 32'(rsp_id), 32'(exp_g1[i]));
            check($sformatf("t2_rsp_c_%0d", i), rsp_c, exp_g1[i] ? 32'd20 : 32'd2);
        end
        set0(1'b0, OP_ADD, 32'd0, 32'd0);
        set1(1'b0, OP_ADD, 32'd0, 32'd0);
        cycle();

        // Sign flag: 2 - 9 = -7
        set1(1'b1, OP_SUB, 32'd2, 32'd9);
        cycle();
        check("t4_rsp_c", rsp_c, 32'hFFFF_FFF9);
        check("t4_rsp_sgn", 32'(rsp_sgn), 32'd1);
        check("t4_rsp_zero", 32'(rsp_zero), 32'd0);
        check("t4_rsp_id", 32'(rsp_id), 32'd1);

        // Back-pressure: 3 - 3 = 0 is held while the consumer stalls.
        set1(1'b1, OP_SUB, 32'd3, 32'd3);
        cycle();
        set1(1'b0, OP_ADD, 32'd0, 32'd0);
        set0(1'b1, OP_ADD, 32'd4, 32'd4);
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("t3_ready0_%0d", i), 32'(req0_ready), 32'd0);
            check($sformatf("t3_ready1_%0d", i), 32'(req1_ready), 32'd0);
            check($sformatf("t3_rsp_valid_%0d", i), 32'(rsp_valid), 32'd1);
            check($sformatf("t3_rsp_c_%0d", i), rsp_c, 32'd0);
            check($sformatf("t3_rsp_zero_%0d", i), 32'(rsp_zero), 32'd1);
            cycle();
        end
        rsp_ready = 1'b1;
        #1;
        check("t3_release_ready0", 32'(req0_ready), 32'd1);
        cycle();
        check("t3_release_rsp_c", rsp_c, 32'd8);
        check("t3_release_rsp_id", 32'(rsp_id), 32'd0);
        check("t3_release_valid", 32'(rsp_valid), 32'd1);

        // Reset mid-operation: build the burst count to 2, then stall with 0x1234 held.
        set0(1'b1, OP_ADD, 32'h1000, 32'h0234);
        set1(1'b1, OP_ADD, 32'd10, 32'd10);
        cycle();
        cycle();
        rsp_ready = 1'b0;
        #1;
        check("t5_pre_rsp_c", rsp_c, 32'h1234);
        check("t5_pre_valid", 32'(rsp_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(rsp_valid), 32'd0);
        check("t5_rst_rsp_c", rsp_c, 32'd0);
        check("t5_rst_ready0", 32'(req0_ready), 32'd0);
        check("t5_rst_ready1", 32'(req1_ready), 32'd0);
        #1 rst_n = 1'b1;
        rsp_ready = 1'b1;
        #1;
        // Burst count was cleared, so port 0 wins the first contended grant.
        check("t5_post_ready0", 32'(req0_ready), 32'd1);
        check("t5_post_ready1", 32'(req1_ready), 32'd0);
        cycle();
        check("t5_post_rsp_id", 32'(rsp_id), 32'd0);
        check("t5_post_rsp_c", rsp_c, 32'h1234);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares the single-cycle EX-stage ALU between two requesters. Port 0 is the core EX path. Port 1 is an auxiliary unit, such as address-generation or debug.
- Each requester presents an op and two operands with a valid/ready handshake.
- The arbiter grants one requester per cycle, drives the combinational ALU, and captures the result with its zero/sgn flags in a one-deep response register.
- The block sits between the operand-select logic and the ALU. It also owns stall generation for the losing requester.

Parameters:
- DW, 32, operand/result width.
- OPW, 4, ALU op-code width.
- P0_BURST, 2, consecutive grants port 0 may take while port 1 is waiting before port 1 is forced.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  port 0 request.
- req0_ready  out  1  port 0 accepted this cycle.
- req0_op  in  OPW  port 0 ALU op.
- req0_a  in  DW  port 0 operand A.
- req0_b  in  DW  port 0 operand B (already muxed RF/SEXT).
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as port 0, for port 1.
- alu_op  out  OPW  to ALU op.
- alu_a  out  DW  to ALU A.
- alu_b  out  DW  to ALU B.
- alu_c  in  DW  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_sgn  in  1  ALU sign flag.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester index of the held result.
- rsp_c  out  DW  captured result.
- rsp_zero  out  1  captured zero flag.
- rsp_sgn  out  1  captured sign flag.

Behaviour:
Reset (rst_n=0, asynchronous):
- rsp_valid=0, rsp_id=0, rsp_c=0, rsp_zero=0, rsp_sgn=0.
- burst counter=0, state=EMPTY.
- req*_ready=0 while in reset.
- alu_op/a/b=0 when no grant.

States:
- EMPTY: response register free.
- FULL: rsp_valid=1.

can_issue:
- can_issue = (state==EMPTY) | rsp_ready.
- This makes back-to-back operation possible: the held result drains while the next op captures in the same cycle.

Grant (combinational, only when can_issue):
- If only one port is valid, that port is granted.
- If both are valid:
  - Port 0 wins unless burst counter == P0_BURST; then port 1 wins.
  - Burst counter increments on a port-0 grant while req1_valid=1.
  - It clears on any port-1 grant, or on any cycle with req1_valid=0.
  - It saturates at P0_BURST.
- reqN_ready = grant N. At most one ready is high per cycle.

ALU mux:
- The granted port's op/a/b drive alu_*. Otherwise all are 0.
- The ALU is combinational.

Capture:
- On the clk edge with a grant: rsp_c<=alu_c, rsp_zero<=alu_zero, rsp_sgn<=alu_sgn, rsp_id<=N, state<=FULL.
- Latency is 1 cycle from accepted request to rsp_valid.

Other transitions:
- FULL & rsp_ready & no grant -> EMPTY. rsp_valid=0 next cycle, and the data fields hold their last values.
- FULL & !rsp_ready: no grant. Both readies are 0, and the response fields are stable.

Handshake rules:
- Requesters must hold op/a/b stable while valid and not ready.
- The arbiter never accepts a request without capturing its result.

Fixed rules:
- Arithmetic is purely in the ALU. This block performs no width change. Operands pass through bit-exact.
- When rsp_ready=1 in EMPTY, the arbiter ignores it.
- Reset asserted mid-operation discards the held response and any pending grant. Requesters must re-present after reset.

Test Plan:
1. Single port 0: req0_valid=1, op=ADD, a=5, b=7, rsp_ready=1 -> req0_ready=1 in the same cycle; next cycle rsp_valid=1, rsp_c=12, rsp_zero=0, rsp_sgn=0, rsp_id=0.
2. Contention fairness: both valid for 6 cycles, rsp_ready=1, P0_BURST=2 -> grant sequence 0,0,1,0,0,1; rsp_id follows one cycle later.
3. Back-pressure: port 1 SUB a=3, b=3 accepted; rsp_ready=0 for 3 cycles -> rsp_valid=1, rsp_c=0, rsp_zero=1 held stable; req0_ready=req1_ready=0 throughout; after rsp_ready=1, the next grant captures in that same cycle.
4. Sign flag: port 1 SUB a=2, b=9 -> rsp_c=0xFFFFFFF9, rsp_sgn=1, rsp_id=1.
5. Reset mid-operation: rsp_valid=1 with rsp_c=0x1234; pulse rst_n low between clock edges -> outputs clear immediately with no clock; burst counter=0; after release, the first contended grant goes to port 0.
6. Idle drain: FULL with rsp_ready=1 and no requests -> rsp_valid=0 next cycle; alu_op/a/b=0; readies 0.
